resp_line_parser: RTL

//  Byte-stream front end for the challenge-response authenticator. Consumes bytes from uart_rx (data/data_valid)
//  and recognises one line "RESP:" + WIDTH/4 hex digits + '\n'. Emits the decoded WIDTH-bit value with a
//  one-cycle valid pulse, or a one-cycle error pulse with a cause code. The authenticator compares the value

---
 rtl/resp_line_parser_pkg.sv | 38 +++
 rtl/resp_line_parser_hex_nibble_decode.sv | 22 ++
 rtl/resp_line_parser.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/resp_line_parser_pkg.sv
// Shared definitions for the response line parser: ASCII constants,
// error cause codes, FSM state encoding and the prefix lookup.
package resp_line_parser_pkg;

  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_E     = 8'h45;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_P     = 8'h50;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;

  typedef enum logic [1:0] {
    ERR_TIMEOUT    = 2'd0,
    ERR_BAD_PREFIX = 2'd1,
    ERR_BAD_DIGIT  = 2'd2,
    ERR_BAD_LENGTH = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_PREFIX = 2'd1,
    S_HEX    = 2'd2,
    S_EOL    = 2'd3
  } state_e;

  // Expected prefix character at position idx of "RESP:" ('R' is idx 0).
  function automatic logic [7:0] prefix_char(input logic [2:0] idx);
    case (idx)
      3'd1:    prefix_char = ASCII_E;
      3'd2:    prefix_char = ASCII_S;
      3'd3:    prefix_char = ASCII_P;
      3'd4:    prefix_char = ASCII_COLON;
      default: prefix_char = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/resp_line_parser_hex_nibble_decode.sv
// Combinational ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f' -> nibble.
module hex_nibble_decode (
  input  logic [7:0] ch,
  output logic [3:0] nibble,
  output logic       is_hex
);

  // Classify the byte and extract its nibble value.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    nibble = 4'h0;
    is_hex = 1'b0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      nibble = ch[3:0];
      is_hex = 1'b1;
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      nibble = ch[3:0] + 4'd9;
      is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/resp_line_parser.sv
// Parses one "RESP:" + WIDTH/4 hex digits + '\n' line from the UART byte
// stream and reports the decoded value or a rejection cause.
module resp_line_parser
  import resp_line_parser_pkg::*;
#(
  parameter int WIDTH          = 128,
  parameter int TIMEOUT_CYCLES = 1_200_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [WIDTH-1:0] resp_value,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [1:0]       err_code
);

  localparam int N     = WIDTH / 4;
  localparam int CNT_W = $clog2(N + 1);
  localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e           state, state_d;
  logic [2:0]       idx, idx_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] shift, shift_d;
  logic             cr_seen, cr_seen_d;
  logic [TMR_W-1:0] timer, timer_d;
  logic [WIDTH-1:0] value_d;
  logic             valid_d, err_d;
  logic [1:0]       code_d;

  logic [3:0]       nib;
  logic             is_hex;
  logic             timeout_hit;

  hex_nibble_decode u_hex (
    .ch     (rx_data),
    .nibble (nib),
    .is_hex (is_hex)
  );

  // The last idle cycle before the limit would bring the timer to TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state != S_HUNT) && (timer == TMR_LAST);

  // Next-state, datapath and output-pulse decisions for one byte or idle cycle.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    cnt_d     = cnt;
    shift_d   = shift;
    cr_seen_d = cr_seen;
    timer_d   = timer;
    value_d   = resp_value;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    code_d    = err_code;

    if (!enable) begin
      // Disabled: drop everything silently and park in HUNT.
      state_d   = S_HUNT;
      idx_d     = '0;
      cnt_d     = '0;
      cr_seen_d = 1'b0;
      timer_d   = '0;
    end else if (rx_valid) begin
      // A byte always wins over a coincident timeout.
      timer_d = '0;
      case (state)
        S_HUNT: begin
          if (rx_data == ASCII_R) begin
            state_d = S_PREFIX;
            idx_d   = 3'd1;
          end
        end
        S_PREFIX: begin
          if (rx_data == prefix_char(idx)) begin
            if (idx == 3'd4) begin
              state_d = S_HEX;
              cnt_d   = '0;
              shift_d = '0;
            end else begin
              idx_d = idx + 3'd1;
            end
          end else begin
            err_d  = 1'b1;
            code_d = ERR_BAD_PREFIX;
            // A stray 'R' may itself be the start of the real line.
            if (rx_data == ASCII_R) idx_d = 3'd1;
            else                    state_d = S_HUNT;
          end
        end
        S_HEX: begin
          if (is_hex) begin
            shift_d = {shift[WIDTH-5:0], nib};
            cnt_d   = cnt + CNT_W'(1);
            if (cnt == CNT_W'(N - 1)) begin
              state_d   = S_EOL;
              cr_seen_d = 1'b0;
            end
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_BAD_DIGIT;
            state_d = S_HUNT;
          end
        end
        S_EOL: begin
          if (rx_data == ASCII_LF) begin
            value_d = shift;
            valid_d = 1'b1;
            state_d = S_HUNT;
          end else if (rx_data == ASCII_CR && !cr_seen) begin
            cr_seen_d = 1'b1;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_BAD_LENGTH;
            state_d = S_HUNT;
          end
        end
        default: state_d = S_HUNT;
      endcase
    end else if (state != S_HUNT && TIMEOUT_CYCLES != 0) begin
      if (timeout_hit) begin
        err_d   = 1'b1;
        code_d  = ERR_TIMEOUT;
        state_d = S_HUNT;
        timer_d = '0;
      end else begin
        timer_d = timer + TMR_W'(1);
      end
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_HUNT;
      idx        <= '0;
      cnt        <= '0;
      shift      <= '0;
      cr_seen    <= 1'b0;
      timer      <= '0;
      resp_value <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      err_code   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, as real flops do.
      state      <= state_d;
      idx        <= idx_d;
      cnt        <= cnt_d;
      shift      <= shift_d;
      cr_seen    <= cr_seen_d;
      timer      <= timer_d;
      resp_value <= value_d;
      resp_valid <= valid_d;
      resp_err   <= err_d;
      err_code   <= code_d;
    end
  end

endmodule
